// File: rtl/y86_fetch_decode_execute.sv
// Single-cycle Y86-64 fetch/decode/execute datapath with register file,
// condition codes and write-back.
module y86_fetch_decode_execute #(
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] PC,
    input  logic [79:0] instr,
    input  logic [63:0] valM,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        mem_error,
    output logic        instr_invalid,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val
);

    localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_CMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3, I_RMMOV = 4'h4, I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8;
    localparam logic [3:0] I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
    localparam logic [3:0] R_RSP = 4'h4, R_NONE = 4'hF;

    logic [63:0] regs_q [15];
    logic [2:0]  cc_q, cc_d;
    logic        need_regs;
    logic [3:0]  len;
    logic [3:0]  dstE, dstM;
    logic        wr_en;
    logic [63:0] rA_val, rB_val, rsp_val;

    function automatic logic cond_eval(input logic [3:0] fn,
                                       input logic [2:0] f);
        logic of, sf, zf;
        of = f[2];
        sf = f[1];
        zf = f[0];
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return (sf ^ of) | zf;
            4'h2:    return sf ^ of;
            4'h3:    return zf;
            4'h4:    return !zf;
            4'h5:    return !(sf ^ of);
            4'h6:    return !(sf ^ of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    assign icode         = instr[79:76];
    assign ifun          = instr[75:72];
    assign mem_error     = (PC >= 64'(IMEM_BYTES));
    assign instr_invalid = (icode > I_POP);
    assign cc            = cc_q;

    always_comb begin
        need_regs = 1'b0;
        len       = 4'd1;
        valC      = 64'd0;
        case (icode)
            I_CMOV, I_OPQ, I_PUSH, I_POP: begin
                need_regs = 1'b1;
                len       = 4'd2;
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                need_regs = 1'b1;
                len       = 4'd10;
                valC      = instr[63:0];
            end
            I_JXX, I_CALL: begin
                len  = 4'd9;
                valC = instr[71:8];
            end
            default: ;
        endcase
    end

    assign rA   = need_regs ? instr[71:68] : R_NONE;
    assign rB   = need_regs ? instr[67:64] : R_NONE;
    assign valP = PC + 64'(len);

    // Index F is "no register" and always reads as zero
    assign rA_val  = (rA == R_NONE) ? 64'd0 : regs_q[rA];
    assign rB_val  = (rB == R_NONE) ? 64'd0 : regs_q[rB];
    assign rsp_val = regs_q[R_RSP];
    assign dbg_val = (dbg_sel == R_NONE) ? 64'd0 : regs_q[dbg_sel];

    always_comb begin
        valA = 64'd0;
        valB = 64'd0;
        case (icode)
            I_CMOV, I_RMMOV, I_OPQ, I_PUSH: valA = rA_val;
            I_RET, I_POP:                   valA = rsp_val;
            default: ;
        endcase
        case (icode)
            I_RMMOV, I_MRMOV, I_OPQ:        valB = rB_val;
            I_CALL, I_RET, I_PUSH, I_POP:   valB = rsp_val;
            default: ;
        endcase
    end

    always_comb begin
        valE = 64'd0;
        cc_d = cc_q;
        case (icode)
            I_CMOV:           valE = valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = valB + valC;
            I_CALL, I_PUSH:   valE = valB - 64'd8;
            I_RET, I_POP:     valE = valB + 64'd8;
            I_OPQ: begin
                case (ifun)
                    4'h1:    valE = valB - valA;
                    4'h2:    valE = valB & valA;
                    4'h3:    valE = valB ^ valA;
                    default: valE = valB + valA;
                endcase
                cc_d[0] = (valE == 64'd0);
                cc_d[1] = valE[63];
                case (ifun)
                    4'h1:       cc_d[2] = (valA[63] != valB[63])
                                       && (valE[63] != valB[63]);
                    4'h2, 4'h3: cc_d[2] = 1'b0;
                    default:    cc_d[2] = (valA[63] == valB[63])
                                       && (valE[63] != valA[63]);
                endcase
            end
            default: ;
        endcase
    end

    assign cnd = (icode == I_JXX || icode == I_CMOV) ? cond_eval(ifun, cc_q)
                                                     : 1'b0;

    always_comb begin
        dstE = R_NONE;
        dstM = R_NONE;
        case (icode)
            I_IRMOV, I_OPQ:               dstE = rB;
            I_CMOV:                       dstE = cnd ? rB : R_NONE;
            I_CALL, I_RET, I_PUSH, I_POP: dstE = R_RSP;
            default: ;
        endcase
        if (icode == I_MRMOV || icode == I_POP) dstM = rA;
    end

    assign wr_en = !mem_error && !instr_invalid
                && icode != I_HALT && icode != I_NOP;

    // M write is issued last so it wins when dstE == dstM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= 64'd0;
            cc_q <= 3'b000;
        end else if (wr_en) begin
            if (dstE != R_NONE) regs_q[dstE] <= valE;
            if (dstM != R_NONE) regs_q[dstM] <= valM;
            if (icode == I_OPQ) cc_q <= cc_d;
        end
    end

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Directed-vector bench for y86_fetch_decode_execute.
module tb_y86_fetch_decode_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] PC;
    logic [79:0] instr;
    logic [63:0] valM;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valA, valB, valE;
    logic        cnd;
    logic [2:0]  cc;
    logic        mem_error, instr_invalid;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;

    int checks = 0;
    int failures = 0;

    y86_fetch_decode_execute #(.IMEM_BYTES(256)) dut (
        .clk(clk), .rst(rst), .PC(PC), .instr(instr), .valM(valM),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
        .cnd(cnd), .cc(cc), .mem_error(mem_error),
        .instr_invalid(instr_invalid),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [63:0] pc, input logic [79:0] ins,
                         input logic [63:0] m);
        PC = pc;
        instr = ins;
        valM = m;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] r, input logic [63:0] exp);
        dbg_sel = r;
        #1;
        checks++;
        if (dbg_val !== exp) begin
            failures++;
            $display("FAIL reg R%0d: got %h expected %h", r, dbg_val, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(64'd0, 80'h10_00_0000000000000000, 64'd0);
        tick();
        for (int i = 0; i < 15; i++) chk_reg(4'(i), 64'd0);
        chk_reg(4'hF, 64'd0);
        chk("reset_cc", 64'(cc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_irmovq();
        drive(64'd0, {8'h30, 8'hF6, 64'hFF}, 64'd0);
        chk("irmov_icode", 64'(icode), 64'h3);
        chk("irmov_rA", 64'(rA), 64'hF);
        chk("irmov_valC", valC, 64'd255);
        chk("irmov_valP", valP, 64'd10);
        chk("irmov_valE", valE, 64'd255);
        tick();
        chk_reg(4'd6, 64'd255);
        drive(64'd10, {8'h30, 8'hF7, 64'h1F}, 64'd0);
        tick();
        chk_reg(4'd7, 64'd31);
    endtask

    task automatic test_rrmovq();
        drive(64'd20, {8'h20, 8'h76, 64'd0}, 64'd0);
        chk("rrmov_cnd", 64'(cnd), 64'd1);
        chk("rrmov_valA", valA, 64'd31);
        chk("rrmov_valP", valP, 64'd22);
        chk("rrmov_valC", valC, 64'd0);
        tick();
        chk_reg(4'd6, 64'd31);
    endtask

    task automatic test_mem_forms();
        drive(64'd0, {8'h30, 8'hF3, 64'd100}, 64'd0);
        tick();
        drive(64'd0, {8'h30, 8'hF5, 64'd5}, 64'd0);
        tick();
        drive(64'd22, {8'h40, 8'h53, 64'd0}, 64'd999);
        chk("rmmov_valA", valA, 64'd5);
        chk("rmmov_valB", valB, 64'd100);
        chk("rmmov_valE", valE, 64'd100);
        chk("rmmov_valP", valP, 64'd32);
        tick();
        chk_reg(4'd3, 64'd100);
        chk_reg(4'd5, 64'd5);
        drive(64'd32, {8'h50, 8'h53, 64'h10}, 64'd77);
        chk("mrmov_valE", valE, 64'd116);
        chk("mrmov_valP", valP, 64'd42);
        tick();
        chk_reg(4'd5, 64'd77);
    endtask

    task automatic test_opq();
        drive(64'd0, {8'h30, 8'hF9, 64'h7FFF_FFFF_FFFF_FFFF}, 64'd0);
        tick();
        drive(64'd0, {8'h30, 8'hFA, 64'd1}, 64'd0);
        tick();
        drive(64'd50, {8'h60, 8'h9A, 64'd0}, 64'd0);
        chk("addq_valE", valE, 64'h8000_0000_0000_0000);
        chk("addq_valP", valP, 64'd52);
        tick();
        chk("addq_cc", 64'(cc), 64'b110);
        chk_reg(4'd10, 64'h8000_0000_0000_0000);
        drive(64'd52, {8'h61, 8'hAA, 64'd0}, 64'd0);
        chk("subq_valE", valE, 64'd0);
        tick();
        chk("subq_cc", 64'(cc), 64'b001);
        drive(64'd100, {8'h73, 64'h123, 8'h00}, 64'd0);
        chk("je_cnd", 64'(cnd), 64'd1);
        chk("je_valP", valP, 64'd109);
        chk("je_valC", valC, 64'h123);
        chk("je_rB", 64'(rB), 64'hF);
        drive(64'd100, {8'h74, 64'h123, 8'h00}, 64'd0);
        chk("jne_cnd", 64'(cnd), 64'd0);
        drive(64'd100, {8'h77, 64'h123, 8'h00}, 64'd0);
        chk("jbad_cnd", 64'(cnd), 64'd0);
        drive(64'd60, {8'h24, 8'h91, 64'd0}, 64'd0);
        chk("cmovne_cnd", 64'(cnd), 64'd0);
        tick();
        chk_reg(4'd1, 64'd0);
    endtask

    task automatic test_stack();
        drive(64'd0, {8'h30, 8'hF4, 64'd64}, 64'd0);
        tick();
        drive(64'd70, {8'hA0, 8'h3F, 64'd0}, 64'd0);
        chk("push_valA", valA, 64'd100);
        chk("push_valE", valE, 64'd56);
        chk("push_valP", valP, 64'd72);
        tick();
        chk_reg(4'd4, 64'd56);
        drive(64'd72, {8'hB0, 8'h4F, 64'd0}, 64'd9);
        chk("pop_valE", valE, 64'd64);
        tick();
        chk_reg(4'd4, 64'd9);
    endtask

    task automatic test_errors();
        drive(64'd0, {8'hC0, 8'h4F, 64'd0}, 64'd0);
        chk("invalid_flag", 64'(instr_invalid), 64'd1);
        tick();
        chk_reg(4'd4, 64'd9);
        chk("invalid_cc", 64'(cc), 64'b001);
        drive(64'd255, {8'h10, 72'd0}, 64'd0);
        chk("pc255_memerr", 64'(mem_error), 64'd0);
        chk("nop_invalid", 64'(instr_invalid), 64'd0);
        drive(64'd256, {8'h30, 8'hF4, 64'h77}, 64'd0);
        chk("pc256_memerr", 64'(mem_error), 64'd1);
        tick();
        chk_reg(4'd4, 64'd9);
    endtask

    task automatic test_reset_mid();
        drive(64'd0, {8'h30, 8'hF1, 64'd5}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_cc", 64'(cc), 64'd0);
        chk_reg(4'd4, 64'd0);
        tick();
        chk_reg(4'd1, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_reg(4'd1, 64'd5);
    endtask

    initial begin
        rst = 1'b1;
        dbg_sel = 4'd0;
        PC = 64'd0;
        instr = 80'd0;
        valM = 64'd0;
        test_reset();
        test_irmovq();
        test_rrmovq();
        test_mem_forms();
        test_opq();
        test_stack();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
